// File: rtl/uart_tx_bus_if.sv
// Bus bundle for uart_tx_bus: one-cycle request strobe from the CPU, one-cycle registered response.
`timescale 1ns/1ps
interface uart_tx_bus_if;
    logic        bus_en;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_en, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_en, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/uart_tx_bus.sv
// Bus-mapped UART transmitter: TX FIFO feeding an 8N1 shifter, 8E1 when UART_TX_PARITY_EN is defined.
// Every bus request is answered one cycle later; pushes into a full FIFO are dropped and flagged in OVF.
`timescale 1ns/1ps
module uart_tx_bus #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_bus_if.slave     bus,
    output logic             uart_rxd_out,
    output logic             uart_tx_int,
    output logic [1:0][31:0] ila_probe
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int DW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_div, w_div_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shreg, w_shreg_nxt;
    logic [7:0]    r_last;
    logic          r_txd, w_txd_nxt;
`ifdef UART_TX_PARITY_EN
    logic          r_par, w_par_nxt;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level;
    logic          r_ovf, r_txie, r_int, r_ready;
    logic [31:0]   r_rdata, w_rdata_nxt;

    logic [1:0]    w_sel;
    logic [7:0]    w_head;
    logic          w_empty, w_full, w_busy, w_pop, w_push_req, w_push, w_rd_status, w_div_zero;
    logic          w_unused;

    assign w_sel       = bus.bus_addr[3:2];
    assign w_head      = r_mem[r_rptr];
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LVL_FULL);
    assign w_busy      = (r_state != S_IDLE);
    assign w_div_zero  = (r_div == '0);
    assign w_push_req  = bus.bus_en & bus.bus_we & (w_sel == 2'd0);
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_rd_status = bus.bus_en & ~bus.bus_we & (w_sel == 2'd1);
    assign w_unused    = ^{bus.bus_addr[1:0], bus.bus_wdata[31:8]};

    always_comb begin
        w_rdata_nxt = '0;
        if (bus.bus_en && !bus.bus_we) begin
            case (w_sel)
                2'd1:    w_rdata_nxt = {16'd0, 8'(r_level), 4'd0, r_ovf, w_busy, w_empty, w_full};
                2'd2:    w_rdata_nxt = {31'd0, r_txie};
                default: w_rdata_nxt = '0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = w_div_zero ? r_div : r_div - DW'(1);
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shreg_nxt = w_head;
`ifdef UART_TX_PARITY_EN
                    w_par_nxt   = ^w_head;
`endif
                    w_state_nxt = S_START;
                    w_div_nxt   = DIV_LAST;
                end
            end
            S_START: begin
                if (w_div_zero) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                    w_div_nxt   = DIV_LAST;
                end
            end
            S_DATA: begin
                if (w_div_zero) begin
                    w_shreg_nxt = {1'b0, r_shreg[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    w_div_nxt   = DIV_LAST;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_div_zero) begin
                    w_state_nxt = S_STOP;
                    w_div_nxt   = DIV_LAST;
                end
            end
`endif
            S_STOP: begin
                if (w_div_zero) begin
                    // Chain straight into the next frame when more data is waiting.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shreg_nxt = w_head;
`ifdef UART_TX_PARITY_EN
                        w_par_nxt   = ^w_head;
`endif
                        w_state_nxt = S_START;
                        w_div_nxt   = DIV_LAST;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Line is registered alongside the state so the pin never glitches.
        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_nxt = w_par_nxt;
`endif
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_last  <= '0;
            r_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
            r_txd   <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
            if (w_pop) r_last <= w_head;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.bus_wdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_txie  <= 1'b0;
            r_int   <= 1'b0;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_push_req && !w_push) r_ovf <= 1'b1;
            else if (w_rd_status)      r_ovf <= 1'b0;
            if (bus.bus_en && bus.bus_we && w_sel == 2'd2) r_txie <= bus.bus_wdata[0];
            r_int   <= r_txie & w_empty & ~w_busy;
            r_ready <= bus.bus_en;
            r_rdata <= w_rdata_nxt;
        end
    end

    assign bus.bus_rdata = r_rdata;
    assign bus.bus_ready = r_ready;
    assign uart_rxd_out  = r_txd;
    assign uart_tx_int   = r_int;
    assign ila_probe[0]  = 32'({r_level, r_state, r_bit});
    assign ila_probe[1]  = 32'({r_last, r_div});
endmodule
